// File: rtl/pipe_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_mem_arbiter_if
// Brief  : Cache-miss request/response and backing-memory bus bundle for
//          pipe_mem_arbiter; slave = arbiter side, master = caches + memory.
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // icache miss port
    logic          i_strobe;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    // dcache miss port
    logic          d_strobe;
    logic          d_rw;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    // backing memory port
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // status
    logic          busy;
    logic          grant_d;

    modport slave (
        input  i_strobe, i_addr,
        input  d_strobe, d_rw, d_addr, d_wdata,
        input  mem_rdata,
        output i_rdata, i_ready,
        output d_rdata, d_ready,
        output mem_addr, mem_we, mem_wdata,
        output busy, grant_d
    );

    modport master (
        output i_strobe, i_addr,
        output d_strobe, d_rw, d_addr, d_wdata,
        output mem_rdata,
        input  i_rdata, i_ready,
        input  d_rdata, d_ready,
        input  mem_addr, mem_we, mem_wdata,
        input  busy, grant_d
    );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pipe_mem_arbiter
// Brief  : Round-robin arbiter sharing one single-port memory between the
//          icache and dcache miss ports with a fixed, programmable latency.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_mem_arbiter #(
    parameter int LATENCY = 5,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic               clock,
    input  logic               reset,
    pipe_mem_arbiter_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [3:0] c_LAT     = 4'(LATENCY);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_op_wr;
    logic          r_grant_d;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_i_ready;
    logic          r_d_ready;

    logic          w_req_any;
    logic          w_win_d;
    logic          w_last;

    // A lone requester always wins; on a tie the port not granted last wins.
    always_comb begin
        w_req_any = bus.i_strobe | bus.d_strobe;
        w_win_d   = bus.d_strobe & (~bus.i_strobe | ~r_grant_d);
        w_last    = (r_cnt == c_LAT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_op_wr     <= 1'b0;
            r_grant_d   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req_any) begin
                        r_grant_d  <= w_win_d;
                        r_op_wr    <= w_win_d & bus.d_rw;
                        r_mem_addr <= w_win_d ? bus.d_addr : bus.i_addr;
                        if (w_win_d) begin
                            r_mem_wdata <= bus.d_wdata;
                        end
                        r_cnt   <= 4'd1;
                        r_state <= c_ST_BUSY;
                    end
                end

                c_ST_BUSY: begin
                    if (w_last) begin
                        if (!r_op_wr) begin
                            if (r_grant_d) begin
                                r_d_rdata <= bus.mem_rdata;
                            end else begin
                                r_i_rdata <= bus.mem_rdata;
                            end
                        end
                        r_d_ready <= r_grant_d;
                        r_i_ready <= ~r_grant_d;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                // Ready pulses here; strobes are ignored until back in IDLE.
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Write strobe is confined to the last BUSY cycle of a dcache write.
    assign bus.mem_we    = (r_state == c_ST_BUSY) & w_last & r_op_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_ready   = r_i_ready;
    assign bus.d_ready   = r_d_ready;
    assign bus.busy      = (r_state == c_ST_BUSY) | (r_state == c_ST_DONE);
    assign bus.grant_d   = r_grant_d;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_mem_arbiter
// Brief  : Directed table-driven bench for pipe_mem_arbiter (LATENCY=5 and 1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipe_mem_arbiter;

    localparam int c_LAT = 5;

    logic clk;
    logic rst;

    pipe_mem_arbiter_if #(.AW(32), .DW(32)) ifc  ();
    pipe_mem_arbiter_if #(.AW(32), .DW(32)) ifc1 ();

    pipe_mem_arbiter #(.LATENCY(c_LAT), .AW(32), .DW(32)) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    pipe_mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed backing memory shared by both instances
    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (ifc.mem_we)
            mem[8'(ifc.mem_addr >> 2)] <= ifc.mem_wdata;
    end
    assign ifc.mem_rdata  = mem[8'(ifc.mem_addr >> 2)];
    assign ifc1.mem_rdata = mem[8'(ifc1.mem_addr >> 2)];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 8'(addr >> 2); pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    typedef struct {
        logic        i_stb;
        logic [31:0] i_addr;
        logic        d_stb;
        logic        d_rw;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_g;
        logic        exp_we;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    // One single-requester transaction: latency, busy length, write pulse, rdata.
    task automatic run_vec(input int n, input vec_t v);
        int lat, nbusy, nwe;
        logic [31:0] we_a, we_d;
        @(negedge clk);
        ifc.i_strobe = v.i_stb; ifc.i_addr = v.i_addr;
        ifc.d_strobe = v.d_stb; ifc.d_rw = v.d_rw;
        ifc.d_addr = v.d_addr;  ifc.d_wdata = v.d_wdata;
        @(posedge clk); #1;
        chk($sformatf("v%0d_accept_busy", n), 32'(ifc.busy), 32'd1);
        chk($sformatf("v%0d_grant_d", n), 32'(ifc.grant_d), 32'(v.exp_g));
        lat = 0; nbusy = 1; nwe = 0; we_a = '0; we_d = '0;
        while (!(ifc.i_ready || ifc.d_ready) && lat < 40) begin
            if (ifc.mem_we) begin
                nwe++; we_a = ifc.mem_addr; we_d = ifc.mem_wdata;
            end
            // Perturb request fields; only latched values may be used
            ifc.i_addr = ~v.i_addr; ifc.d_addr = ~v.d_addr;
            ifc.d_wdata = 32'h5555_AAAA; ifc.d_rw = !v.d_rw;
            @(posedge clk); #1;
            lat++;
            if (ifc.busy) nbusy++;
        end
        chk($sformatf("v%0d_latency", n), 32'(lat), 32'(c_LAT));
        chk($sformatf("v%0d_busy_cycles", n), 32'(nbusy), 32'(c_LAT + 1));
        chk($sformatf("v%0d_we_cycles", n), 32'(nwe), 32'(v.exp_we));
        if (v.exp_we) begin
            chk($sformatf("v%0d_we_addr", n), we_a, v.d_addr);
            chk($sformatf("v%0d_we_data", n), we_d, v.d_wdata);
        end
        chk($sformatf("v%0d_i_ready", n), 32'(ifc.i_ready), 32'(!v.exp_g));
        chk($sformatf("v%0d_d_ready", n), 32'(ifc.d_ready), 32'(v.exp_g));
        ifc.i_strobe = 1'b0; ifc.d_strobe = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready_clear", n), 32'(ifc.i_ready | ifc.d_ready), 32'd0);
        chk($sformatf("v%0d_idle", n), 32'(ifc.busy), 32'd0);
        chk($sformatf("v%0d_i_rdata", n), ifc.i_rdata, v.exp_i);
        chk($sformatf("v%0d_d_rdata", n), ifc.d_rdata, v.exp_d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, guard, ni, nd;
        logic [8:0] exp_busy1, exp_rdy1;
        logic [3:0] exp_gnt;

        rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        ifc.i_strobe = 0; ifc.i_addr = '0; ifc.d_strobe = 0; ifc.d_rw = 0;
        ifc.d_addr = '0; ifc.d_wdata = '0;
        ifc1.i_strobe = 0; ifc1.i_addr = '0; ifc1.d_strobe = 0; ifc1.d_rw = 0;
        ifc1.d_addr = '0; ifc1.d_wdata = '0;

        preload(32'h40,  32'h8C22_0004);
        preload(32'h44,  32'h1111_2222);
        preload(32'h80,  32'h0000_0000);
        preload(32'h84,  32'h0000_0000);
        preload(32'h100, 32'h0BAD_F00D);

        chk("rst_busy",   32'(ifc.busy), 32'd0);
        chk("rst_grant",  32'(ifc.grant_d), 32'd0);
        chk("rst_ready",  32'(ifc.i_ready | ifc.d_ready), 32'd0);
        chk("rst_we",     32'(ifc.mem_we), 32'd0);
        chk("rst_addr",   ifc.mem_addr, 32'd0);
        chk("rst_i_rdata", ifc.i_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_strobe", 32'(ifc.busy), 32'd0);

        //          i_stb i_addr      d_stb rw  d_addr      d_wdata        g     we    exp_i           exp_d
        vecs[0] = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,  32'h0,          1'b0, 1'b0, 32'h8C22_0004, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF,  1'b1, 1'b1, 32'h8C22_0004, 32'h0};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h80, 32'h0,          1'b1, 1'b0, 32'h8C22_0004, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,          1'b0, 1'b0, 32'h0BAD_F00D, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h44, 32'h0,          1'b1, 1'b0, 32'h0BAD_F00D, 32'h1111_2222};
        vecs[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h44, 32'hCAFE_0001,  1'b1, 1'b1, 32'h0BAD_F00D, 32'h1111_2222};
        vecs[6] = '{1'b1, 32'h44,  1'b0, 1'b0, 32'h0,  32'h0,          1'b0, 1'b0, 32'hCAFE_0001, 32'h1111_2222};
        for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

        // Both strobes held from reset: grants alternate d, i, d, i
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rr_rst_rdata", ifc.d_rdata, 32'd0);
        ifc.i_strobe = 1; ifc.i_addr = 32'h40;
        ifc.d_strobe = 1; ifc.d_rw = 0; ifc.d_addr = 32'h80;
        exp_gnt = 4'b0101;
        ni = 0; nd = 0;
        for (int t = 0; t < 4; t++) begin
            guard = 0;
            do begin @(posedge clk); #1; guard++; end while (!ifc.busy && guard < 10);
            chk($sformatf("rr%0d_grant_d", t), 32'(ifc.grant_d), 32'(exp_gnt[t]));
            guard = 0;
            while (!(ifc.i_ready || ifc.d_ready) && guard < 20) begin
                @(posedge clk); #1; guard++;
            end
            if (ifc.i_ready) ni++;
            if (ifc.d_ready) nd++;
            chk($sformatf("rr%0d_winner_ready", t),
                32'(exp_gnt[t] ? ifc.d_ready : ifc.i_ready), 32'd1);
            @(posedge clk); #1;
        end
        chk("rr_i_count", 32'(ni), 32'd2);
        chk("rr_d_count", 32'(nd), 32'd2);
        chk("rr_i_rdata", ifc.i_rdata, 32'h8C22_0004);
        chk("rr_d_rdata", ifc.d_rdata, 32'hDEAD_BEEF);
        ifc.i_strobe = 0; ifc.d_strobe = 0;
        repeat (c_LAT + 2) @(posedge clk);
        #1;

        // dcache strobe rises in icache BUSY cycle 2; waits for next IDLE edge
        @(negedge clk);
        ifc.i_strobe = 1; ifc.i_addr = 32'h100;
        @(posedge clk); #1;
        chk("late_i_grant", 32'(ifc.grant_d), 32'd0);
        @(posedge clk); #1;
        lat = 1;
        ifc.d_strobe = 1; ifc.d_rw = 0; ifc.d_addr = 32'h40;
        while (!ifc.i_ready && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("late_i_latency", 32'(lat), 32'(c_LAT));
        chk("late_i_grant_hold", 32'(ifc.grant_d), 32'd0);
        chk("late_i_rdata", ifc.i_rdata, 32'h0BAD_F00D);
        ifc.i_strobe = 0;
        @(posedge clk); #1;
        chk("late_done_idle", 32'(ifc.busy), 32'd0);
        @(posedge clk); #1;
        chk("late_d_accept", 32'(ifc.busy), 32'd1);
        chk("late_d_grant", 32'(ifc.grant_d), 32'd1);
        chk("late_d_addr", ifc.mem_addr, 32'h40);
        guard = 0;
        while (!ifc.d_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        ifc.d_strobe = 0;
        chk("late_d_rdata", ifc.d_rdata, 32'h8C22_0004);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a dcache write
        @(negedge clk);
        ifc.d_strobe = 1; ifc.d_rw = 1; ifc.d_addr = 32'h84; ifc.d_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("abort_grant", 32'(ifc.grant_d), 32'd1);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_grant0", 32'(ifc.grant_d), 32'd0);
        chk("abort_we", 32'(ifc.mem_we), 32'd0);
        chk("abort_addr", ifc.mem_addr, 32'd0);
        chk("abort_wdata", ifc.mem_wdata, 32'd0);
        chk("abort_rdata", ifc.i_rdata | ifc.d_rdata, 32'd0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ifc.mem_we || ifc.d_ready) bad++;
        end
        chk("abort_no_pulse", 32'(bad), 32'd0);
        chk("abort_no_write", mem[33], 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("reaccept_busy", 32'(ifc.busy), 32'd1);
        chk("reaccept_grant", 32'(ifc.grant_d), 32'd1);
        guard = 0;
        while (!ifc.d_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        ifc.d_strobe = 0;
        chk("reaccept_ready", 32'(ifc.d_ready), 32'd1);
        chk("reaccept_write", mem[33], 32'h1234_5678);

        // LATENCY=1 instance with i_strobe held
        @(negedge clk);
        ifc1.i_strobe = 1; ifc1.i_addr = 32'h40;
        exp_busy1 = 9'b011_011_011;
        exp_rdy1  = 9'b010_010_010;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            chk($sformatf("l1_busy%0d", c), 32'(ifc1.busy), 32'(exp_busy1[c]));
            chk($sformatf("l1_ready%0d", c), 32'(ifc1.i_ready), 32'(exp_rdy1[c]));
            chk($sformatf("l1_quiet%0d", c), 32'(ifc1.mem_we | ifc1.d_ready), 32'd0);
        end
        ifc1.i_strobe = 0;
        chk("l1_i_rdata", ifc1.i_rdata, 32'h8C22_0004);
        chk("l1_d_rdata", ifc1.d_rdata, 32'd0);
        chk("l1_grant", 32'(ifc1.grant_d), 32'd0);
        chk("l1_wdata", ifc1.mem_wdata, 32'd0);
        chk("l1_addr", ifc1.mem_addr, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-port backing memory between the instruction-cache miss port and the data-cache miss port.
- Sequences each access with a programmable fixed latency, replacing the free-running wait counter used for the memory-ready signal.
- Placement: between the pipeline caches (icache and dcache memory-side interfaces) and the memory model.
- Handshake to each cache: strobe/ready, where strobe is held until ready.

Parameters:
- LATENCY, 5: memory access cycles per transaction; legal 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_strobe  in  1  icache miss request, held until i_ready.
- i_addr  in  AW  icache request address.
- i_rdata  out  DW  read data returned to icache.
- i_ready  out  1  one-cycle completion pulse to icache.
- d_strobe  in  1  dcache request, held until d_ready.
- d_rw  in  1  dcache operation: 1 = write, 0 = read.
- d_addr  in  AW  dcache request address.
- d_wdata  in  DW  dcache write data.
- d_rdata  out  DW  read data returned to dcache.
- d_ready  out  1  one-cycle completion pulse to dcache.
- mem_addr  out  AW  address to backing memory.
- mem_we  out  1  write enable to backing memory.
- mem_wdata  out  DW  write data to backing memory.
- mem_rdata  in  DW  read data from backing memory (combinational from mem_addr).
- busy  out  1  high while state is BUSY or DONE.
- grant_d  out  1  current or last owner: 1 = dcache, 0 = icache.

Behaviour:
- Reset (asynchronous, any state including mid-transaction):
  - state=IDLE, cnt=0, last_grant=icache.
  - i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, grant_d=0.
  - An aborted transaction never produces ready and never produces mem_we.
- IDLE, at a posedge with any strobe high:
  - Arbitrate and latch addr, rw and wdata of the winner into mem_addr, op and mem_wdata.
  - Set grant_d, cnt=1, state->BUSY.
- IDLE with no strobe: all outputs hold; ready signals stay 0.
- Arbitration when both strobes are high:
  - Grant the requester not granted last (round-robin).
  - last_grant is updated on each grant.
  - The first tie after reset goes to dcache.
  - A single requester always wins.
- BUSY:
  - mem_addr and mem_wdata are stable from registers for the whole state.
  - At each posedge with cnt<LATENCY: cnt++.
  - At the posedge with cnt==LATENCY:
    - Read: capture mem_rdata into the winner's rdata register.
    - Assert the winner's ready (registered), state->DONE.
  - BUSY lasts exactly LATENCY cycles.
- mem_we:
  - High only during the final BUSY cycle (cnt==LATENCY) of a dcache write.
  - Never high for reads or for icache transactions.
- DONE: the winner's ready is high for exactly one cycle, then clears; state->IDLE.
- DONE never accepts a new request. The requester drops strobe after seeing ready, so IDLE does not re-trigger. Minimum request-to-request spacing is LATENCY+2 cycles.
- Latency: request accepted at edge k; ready is high during the cycle after edge k+LATENCY.
- The rdata of the non-granted port is never modified. Each rdata holds its value until that port's next read completes.
- A strobe dropped mid-BUSY does not cancel the transaction: it completes and ready still pulses.
- A strobe that rises during BUSY or DONE waits; it is arbitrated at the next IDLE edge.
- Address, data and rw changes during BUSY are ignored; only latched values are used.
- Widths:
  - cnt is 4 bits and never wraps (LATENCY≤15).
  - No arithmetic on addresses; the address is passed through unmodified.

Test Plan:
- Reset, then i_strobe=1, i_addr=0x40, memory word 0x40=0x8C220004, LATENCY=5:
  - i_ready pulses exactly once, 5 cycles after acceptance (busy high for 6 cycles).
  - i_rdata=0x8C220004; mem_we stays 0.
- d_strobe=1, d_rw=1, d_addr=0x80, d_wdata=0xDEADBEEF:
  - mem_we is high for exactly 1 cycle (the final BUSY cycle) with mem_addr=0x80 and mem_wdata=0xDEADBEEF.
  - d_ready then pulses; a following read of 0x80 returns 0xDEADBEEF.
- Both strobes held high continuously from reset:
  - Grant order is d, i, d, i (grant_d = 1, 0, 1, 0).
  - Each ready pulses once per transaction; neither port is starved.
- d_strobe rises while an icache transaction is in BUSY cycle 2:
  - The icache transaction completes untouched.
  - The dcache transaction is accepted at the first IDLE edge after DONE.
- reset asserted asynchronously during BUSY of a dcache write:
  - All outputs are 0 immediately; no mem_we pulse and no d_ready.
  - After reset releases, a held d_strobe is re-accepted from IDLE.
- LATENCY=1 build, i_strobe held: ready is high during the cycle after the edge following acceptance; busy is high 2 cycles per transaction; back-to-back transactions are spaced 3 cycles.
